sr_piso_tx: RTL and testbench

Parallel-in serial-out shift register transmitter, W bits per frame. It serialises a parallel word onto a single-bit line, which makes it the transmit end feeding the team's 8-bit SIPO receiver. A valid/ready load handshake accepts the word, and a shift_en strobe paces each bit. A one-cycle done pulse marks the end of each frame.

---
 rtl/sr_pkg.sv | 19 +
 rtl/sr_bit_counter.sv | 30 +++
 rtl/sr_piso_tx.sv | 135 +++++++++++++
 tb/tb_sr_piso_tx.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/sr_pkg.sv
// Shared definitions for the serial shift-register family (PISO transmitter,
// SIPO receiver): FSM state encoding, default width and bit-order select.
package sr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } sr_state_t;

  localparam int SR_DEFAULT_W = 8;

  // Pick the bit at the output end of the shift register for the given order.
  function automatic logic sr_out_bit(input logic msb, input logic lsb,
                                      input logic lsb_first);
    return lsb_first ? lsb : msb;
  endfunction

endpackage

// File: rtl/sr_bit_counter.sv
// Modulo-MOD bit counter with synchronous clear and enable and a
// terminal-count flag (cnt == MOD-1). Frames bits for serial TX and RX.
module sr_bit_counter #(
  parameter int MOD = 8,
  parameter int CW  = (MOD > 1) ? $clog2(MOD) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  localparam logic [CW-1:0] LAST = CW'(MOD - 1);

  assign tc = (cnt == LAST);

  // Count enabled bits, wrapping after MOD-1; clear wins over enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sr_piso_tx.sv
// Parallel-in serial-out transmitter: valid/ready load of a W-bit word,
// one bit per shift_en strobe, one-cycle done pulse after the frame.
// Optional trailing even-parity bit when SR_PISO_PARITY_EN is defined.
module sr_piso_tx
  import sr_pkg::*;
#(
  parameter int W         = SR_DEFAULT_W,
  parameter int LSB_FIRST = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] load_data,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic         shift_en,
  output logic         sout,
  output logic         sout_valid,
  output logic         busy,
  output logic         done
);

  localparam int            CW      = $clog2(W);
  localparam logic [CW-1:0] LAST    = CW'(W - 1);
  localparam logic          LSB_SEL = (LSB_FIRST != 0);

  sr_state_t     state, state_nx;
  logic [W-1:0]  shreg;
  logic [CW-1:0] cnt;
  logic          cnt_tc;
  logic          ready_q;
  logic          done_q;
  logic          load_fire;
  logic          shift_fire;
  logic          frame_end;
`ifdef SR_PISO_PARITY_EN
  logic          par_q;
`endif

  sr_bit_counter #(.MOD(W), .CW(CW)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (load_fire),
    .en    (shift_fire),
    .cnt   (cnt),
    .tc    (cnt_tc)
  );

  assign done = done_q;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and outputs; ready_q keeps load_ready low until the first
  // edge after reset release.
  always_comb begin
    state_nx   = state;
    load_ready = 1'b0;
    busy       = 1'b0;
    sout_valid = 1'b0;
    sout       = 1'b0;
    load_fire  = 1'b0;
    shift_fire = 1'b0;
    frame_end  = 1'b0;
    case (state)
      IDLE: begin
        load_ready = ready_q;
        if (load_valid && ready_q) begin
          load_fire = 1'b1;
          state_nx  = SHIFT;
        end
      end
      SHIFT: begin
        busy       = 1'b1;
        sout_valid = 1'b1;
        sout       = sr_out_bit(shreg[W-1], shreg[0], LSB_SEL);
        if (shift_en) begin
          if (cnt_tc) begin
`ifdef SR_PISO_PARITY_EN
            state_nx  = PARITY;
`else
            state_nx  = IDLE;
            frame_end = 1'b1;
`endif
          end else if (cnt < LAST) begin
            shift_fire = 1'b1;
          end
        end
      end
`ifdef SR_PISO_PARITY_EN
      PARITY: begin
        busy       = 1'b1;
        sout_valid = 1'b1;
        sout       = par_q;
        if (shift_en) begin
          state_nx  = IDLE;
          frame_end = 1'b1;
        end
      end
`endif
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Shift register, parity latch, done pulse and post-reset ready flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg   <= '0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
`ifdef SR_PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      ready_q <= 1'b1;
      done_q  <= frame_end;
      if (load_fire) begin
        shreg <= load_data;
`ifdef SR_PISO_PARITY_EN
        par_q <= ^load_data;
`endif
      end else if (shift_fire) begin
        shreg <= LSB_SEL ? (shreg >> 1) : (shreg << 1);
      end
    end
  end

endmodule

// File: tb/tb_sr_piso_tx.sv
// Bench for sr_piso_tx: an MSB-first and an LSB-first instance, directed
// and randomized frames checked bit-by-bit against a frame model.
module tb_sr_piso_tx;

  localparam int W = 8;
`ifdef SR_PISO_PARITY_EN
  localparam int NBITS = W + 1;
`else
  localparam int NBITS = W;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] ld0 = '0, ld1 = '0;
  logic         lv0 = 1'b0, lv1 = 1'b0;
  logic         se0 = 1'b0, se1 = 1'b0;
  logic         lr0, so0, sv0, bz0, dn0;
  logic         lr1, so1, sv1, bz1, dn1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sr_piso_tx #(.W(W), .LSB_FIRST(0)) dut_msb (
    .clk(clk), .reset(reset), .load_data(ld0), .load_valid(lv0),
    .load_ready(lr0), .shift_en(se0), .sout(so0), .sout_valid(sv0),
    .busy(bz0), .done(dn0)
  );

  sr_piso_tx #(.W(W), .LSB_FIRST(1)) dut_lsb (
    .clk(clk), .reset(reset), .load_data(ld1), .load_valid(lv1),
    .load_ready(lr1), .shift_en(se1), .sout(so1), .sout_valid(sv1),
    .busy(bz1), .done(dn1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // k-th transmitted bit of a frame carrying word w.
  function automatic logic model_bit(input logic [W-1:0] w, input int k, input bit lsb);
    if (k >= W) return ^w;
    return lsb ? w[k] : w[W-1-k];
  endfunction

  task automatic drive(input int which, input logic lv, input logic [W-1:0] ld, input logic se);
    if (which == 0) begin lv0 = lv; ld0 = ld; se0 = se; end
    else            begin lv1 = lv; ld1 = ld; se1 = se; end
  endtask

  task automatic outs(input int which, output logic lr, output logic so,
                      output logic sv, output logic bz, output logic dn);
    if (which == 0) begin lr = lr0; so = so0; sv = sv0; bz = bz0; dn = dn0; end
    else            begin lr = lr1; so = so1; sv = sv1; bz = bz1; dn = dn1; end
  endtask

  // Sends one frame starting at a negedge with the DUT ready.
  // mode 0: shift_en always 1; 1: every other cycle; 2: random.
  // intrude: pulse load_valid with all-ones mid-frame.
  // rst_at: abort with reset when that bit index is on sout (-1 = never).
  task automatic send(input int which, input logic [W-1:0] word, input int mode,
                      input bit intrude, input int rst_at);
    logic lr, so, sv, bz, dn, se;
    int idx, cyc;
    outs(which, lr, so, sv, bz, dn);
    chk("ready_before_load", lr, 1'b1);
    drive(which, 1'b1, word, 1'b0);
    @(negedge clk);
    drive(which, 1'b0, 'x, 1'b0);
    idx = 0;
    cyc = 0;
    while (idx < NBITS && cyc < 100) begin
      outs(which, lr, so, sv, bz, dn);
      chk("sout_valid", sv, 1'b1);
      chk("busy", bz, 1'b1);
      chk("ready_in_frame", lr, 1'b0);
      chk("done_in_frame", dn, 1'b0);
      chk($sformatf("sout_bit%0d", idx), so, model_bit(word, idx, which == 1));
      if (rst_at == idx) begin
        #1 reset = 1'b0;
        #1;
        outs(which, lr, so, sv, bz, dn);
        chk("abort_sout", so, 1'b0);
        chk("abort_valid", sv, 1'b0);
        chk("abort_busy", bz, 1'b0);
        chk("abort_ready", lr, 1'b0);
        drive(which, 1'b0, '0, 1'b0);
        repeat (2) begin
          @(negedge clk);
          outs(which, lr, so, sv, bz, dn);
          chk("abort_no_done", dn, 1'b0);
        end
        reset = 1'b1;
        @(negedge clk);
        outs(which, lr, so, sv, bz, dn);
        chk("abort_ready_after", lr, 1'b1);
        chk("abort_no_done_after", dn, 1'b0);
        return;
      end
      case (mode)
        0:       se = 1'b1;
        1:       se = (cyc % 2 == 1);
        default: se = logic'($urandom_range(0, 1));
      endcase
      if (intrude && cyc == 3) drive(which, 1'b1, 8'hFF, se);
      else                     drive(which, 1'b0, 'x, se);
      @(negedge clk);
      cyc++;
      if (se) idx++;
    end
    chk("frame_timeout", (idx == NBITS), 1'b1);
    drive(which, 1'b0, '0, 1'b0);
    outs(which, lr, so, sv, bz, dn);
    chk("done_pulse", dn, 1'b1);
    chk("done_ready", lr, 1'b1);
    chk("done_valid_low", sv, 1'b0);
    chk("done_busy_low", bz, 1'b0);
    if (mode == 0) chk("valid_cycles", cyc, NBITS);
    if (mode == 1) chk("valid_cycles_paced", cyc, 2 * NBITS);
  endtask

  task automatic idle_check(input int which, input string tag);
    logic lr, so, sv, bz, dn;
    @(negedge clk);
    outs(which, lr, so, sv, bz, dn);
    chk({tag, "_done_once"}, dn, 1'b0);
    chk({tag, "_idle_valid"}, sv, 1'b0);
    chk({tag, "_idle_sout"}, so, 1'b0);
  endtask

  initial begin
    logic [W-1:0] w;
    // Reset held with load_valid asserted.
    lv0 = 1'b1; ld0 = 8'h3C; lv1 = 1'b1; ld1 = 8'h3C;
    repeat (2) @(negedge clk);
    chk("rst_sout", so0, 1'b0);
    chk("rst_valid", sv0, 1'b0);
    chk("rst_done", dn0, 1'b0);
    chk("rst_ready", lr0, 1'b0);
    chk("rst_busy", bz0, 1'b0);
    reset = 1'b1;
    #1 chk("ready_before_edge", lr0, 1'b0);
    @(negedge clk);
    chk("ready_after_edge", lr0, 1'b1);
    chk("no_frame_without_hs", sv0, 1'b0);
    lv0 = 1'b0; lv1 = 1'b0;
    @(negedge clk);
    chk("still_idle", sv1, 1'b0);

    // MSB-first, constant shift_en.
    send(0, 8'hA5, 0, 1'b0, -1);
    idle_check(0, "a5");
    // Paced frame with ignored mid-frame load.
    send(0, 8'hC3, 1, 1'b1, -1);
    idle_check(0, "c3");
    // LSB-first, back-to-back frames.
    send(1, 8'h01, 0, 1'b0, -1);
    send(1, 8'h80, 0, 1'b0, -1);
    idle_check(1, "b2b");
    // Reset mid-frame, then a clean frame.
    send(0, 8'hFF, 0, 1'b0, 3);
    send(0, 8'h5A, 0, 1'b0, -1);
    idle_check(0, "5a");
    // Parity-oriented words (plain data frames in the default build).
    send(0, 8'h07, 0, 1'b0, -1);
    send(0, 8'h03, 0, 1'b0, -1);
    idle_check(0, "par");
    // Randomized words and pacing on both bit orders.
    for (int i = 0; i < 12; i++) begin
      w = W'($urandom);
      send(i % 2, w, 2, (i % 3 == 0), -1);
      if (i % 4 == 3) idle_check(i % 2, "rnd");
    end
    idle_check(0, "end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
